cnn_conv_1x1_stream: RTL and testbench

// - Parametrised streaming 1x1 convolution engine: loads a COUT x CIN signed fixed-point weight matrix.
// - Then, per pixel, consumes CIN channel-interleaved samples and emits COUT outputs through an output FIFO.
// - Output handshake is ready/valid. Replaces fixed-size 1x1 conv/adder/align chains in the conv_1x1 layers.

---
 rtl/cnn_conv_1x1_stream.sv | 168 ++++++++++++++++
 tb/tb_cnn_conv_1x1_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_1x1_stream.sv
// Streaming 1x1 convolution engine: weight RAM load, per-pixel channel buffer, serial 2-stage MAC, FWFT output FIFO.
// Build macro CONV1X1_RELU_EN clamps negative saturated results to zero before the FIFO write.
module cnn_conv_1x1_stream #(
   parameter int DATA_WIDTH       = 16,
   parameter int FRAC_BITS        = 8,
   parameter int CIN              = 64,
   parameter int COUT             = 128,
   parameter int IMAGE_SIZE       = 4096,
   parameter int FIFO_DEPTH       = 16,
   parameter int RELOAD_PER_FRAME = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_weight_in,
   input  logic [DATA_WIDTH-1:0] weight_in,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] pxl_in,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] pxl_out,
   output logic                  valid_out,
   input  logic                  out_ready,
   output logic                  frame_done
);

   localparam int DW    = DATA_WIDTH;
   localparam int WN    = COUT * CIN;
   localparam int WA_W  = (WN > 1) ? $clog2(WN) : 1;
   localparam int IC_W  = (CIN > 1) ? $clog2(CIN) : 1;
   localparam int OC_W  = (COUT > 1) ? $clog2(COUT) : 1;
   localparam int FA_W  = $clog2(FIFO_DEPTH);
   localparam int FC_W  = FA_W + 1;
   localparam int PIX_W = $clog2(IMAGE_SIZE + 1);
   localparam int PW    = 2 * DW;
   localparam int ACC_W = PW + $clog2(CIN);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

   typedef enum logic [1:0] {W_LOAD, PX_LOAD, COMPUTE} state_t;

   state_t state_q, state_d;

   logic signed [DW-1:0]    w_ram  [WN];
   logic signed [DW-1:0]    px_buf [CIN];
   logic [DW-1:0]           fifo_mem [FIFO_DEPTH];

   logic [WA_W-1:0]         wcnt, w_idx;
   logic [IC_W-1:0]         icnt, ic_cnt;
   logic [OC_W-1:0]         oc_cnt;
   logic [PIX_W-1:0]        pix_cnt;
   logic                    issue_done;
   logic                    s1_valid, s1_first, s1_last, s1_final;
   logic                    s2_last, s2_final;
   logic signed [PW-1:0]    prod_q;
   logic signed [ACC_W-1:0] acc_q, shifted;
   logic [FA_W-1:0]         wr_ptr, rd_ptr;
   logic [FC_W-1:0]         fifo_cnt, inflight;
   logic                    frame_done_q;

   logic          issue, stall, last_ic, last_oc, wr_en, rd_en, frame_end;
   logic [DW-1:0] res;

   // Credits: a result is reserved a FIFO slot as soon as its last term issues.
   assign inflight  = FC_W'(s1_valid & s1_last) + FC_W'(s2_last);
   assign stall     = (fifo_cnt + inflight) >= FC_W'(FIFO_DEPTH);
   assign issue     = (state_q == COMPUTE) && !issue_done && !stall;
   assign last_ic   = ic_cnt == IC_W'(CIN - 1);
   assign last_oc   = oc_cnt == OC_W'(COUT - 1);
   assign wr_en     = s2_last;
   assign rd_en     = (fifo_cnt != '0) && out_ready;
   assign frame_end = s2_final && (pix_cnt == PIX_W'(IMAGE_SIZE - 1));

   assign in_ready   = (state_q == PX_LOAD);
   assign valid_out  = (fifo_cnt != '0);
   assign pxl_out    = valid_out ? fifo_mem[rd_ptr] : '0;
   assign frame_done = frame_done_q;

   // Floor shift, then clamp into the DW-bit signed range.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
      res     = '0;
      shifted = acc_q >>> FRAC_BITS;
      if (shifted > SAT_MAX)
         res = {1'b0, {(DW - 1){1'b1}}};
      else if (shifted < SAT_MIN)
         res = {1'b1, {(DW - 1){1'b0}}};
      else
         res = shifted[DW-1:0];
`ifdef CONV1X1_RELU_EN
      if (res[DW-1])
         res = '0;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         W_LOAD:  if (valid_weight_in && wcnt == WA_W'(WN - 1)) state_d = PX_LOAD;
         PX_LOAD: if (valid_in && icnt == IC_W'(CIN - 1))      state_d = COMPUTE;
         COMPUTE: if (s2_final)
                     state_d = (frame_end && RELOAD_PER_FRAME != 0) ? W_LOAD : PX_LOAD;
         default: state_d = W_LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= W_LOAD;
         wcnt         <= '0;
         icnt         <= '0;
         w_idx        <= '0;
         ic_cnt       <= '0;
         oc_cnt       <= '0;
         pix_cnt      <= '0;
         issue_done   <= 1'b0;
         s1_valid     <= 1'b0;
         s1_first     <= 1'b0;
         s1_last      <= 1'b0;
         s1_final     <= 1'b0;
         s2_last      <= 1'b0;
         s2_final     <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= frame_end;
         if (state_q == W_LOAD && valid_weight_in)
            wcnt <= (wcnt == WA_W'(WN - 1)) ? '0 : wcnt + 1'b1;
         if (in_ready && valid_in)
            icnt <= (icnt == IC_W'(CIN - 1)) ? '0 : icnt + 1'b1;
         if (issue) begin
            w_idx  <= (last_ic && last_oc) ? '0 : w_idx + 1'b1;
            ic_cnt <= last_ic ? '0 : ic_cnt + 1'b1;
            if (last_ic) oc_cnt <= last_oc ? '0 : oc_cnt + 1'b1;
            if (last_ic && last_oc) issue_done <= 1'b1;
         end
         if (s2_final) begin
            issue_done <= 1'b0;
            pix_cnt    <= frame_end ? '0 : pix_cnt + 1'b1;
         end
         s1_valid <= issue;
         s1_first <= (ic_cnt == '0);
         s1_last  <= last_ic;
         s1_final <= last_ic && last_oc;
         s2_last  <= s1_valid && s1_last;
         s2_final <= s1_valid && s1_final;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // NOTE: storage arrays and datapath registers are not reset; valid flags above gate every use.
   always_ff @(posedge clk) begin
      if (state_q == W_LOAD && valid_weight_in) w_ram[wcnt] <= weight_in;
      if (in_ready && valid_in)                 px_buf[icnt] <= pxl_in;
      if (issue)    prod_q <= PW'(w_ram[w_idx]) * PW'(px_buf[ic_cnt]);
      if (s1_valid) acc_q  <= s1_first ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
      if (wr_en)    fifo_mem[wr_ptr] <= res;
   end

endmodule

// File: tb/tb_cnn_conv_1x1_stream.sv
// Directed bench for cnn_conv_1x1_stream: three configurations (2x2 reload, 8x2 keep, 2x2 Q8) share one clock.
// Expected values honour the CONV1X1_RELU_EN build macro.
module tb_cnn_conv_1x1_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_s [3];
   logic        vw_s    [3];
   logic [15:0] wi_s    [3];
   logic        vi_s    [3];
   logic [15:0] pi_s    [3];
   logic        or_s    [3];
   logic        ir_s    [3];
   logic [15:0] po_s    [3];
   logic        vo_s    [3];
   logic        fd_s    [3];

   cnn_conv_1x1_stream #(.DATA_WIDTH(16), .FRAC_BITS(0), .CIN(2), .COUT(2), .IMAGE_SIZE(2),
                         .FIFO_DEPTH(4), .RELOAD_PER_FRAME(1)) dut_a (
      .clk(clk), .reset(reset_s[0]), .valid_weight_in(vw_s[0]), .weight_in(wi_s[0]),
      .valid_in(vi_s[0]), .pxl_in(pi_s[0]), .in_ready(ir_s[0]), .pxl_out(po_s[0]),
      .valid_out(vo_s[0]), .out_ready(or_s[0]), .frame_done(fd_s[0]));

   cnn_conv_1x1_stream #(.DATA_WIDTH(16), .FRAC_BITS(0), .CIN(2), .COUT(8), .IMAGE_SIZE(2),
                         .FIFO_DEPTH(4), .RELOAD_PER_FRAME(0)) dut_b (
      .clk(clk), .reset(reset_s[1]), .valid_weight_in(vw_s[1]), .weight_in(wi_s[1]),
      .valid_in(vi_s[1]), .pxl_in(pi_s[1]), .in_ready(ir_s[1]), .pxl_out(po_s[1]),
      .valid_out(vo_s[1]), .out_ready(or_s[1]), .frame_done(fd_s[1]));

   cnn_conv_1x1_stream #(.DATA_WIDTH(16), .FRAC_BITS(8), .CIN(2), .COUT(2), .IMAGE_SIZE(2),
                         .FIFO_DEPTH(4), .RELOAD_PER_FRAME(1)) dut_c (
      .clk(clk), .reset(reset_s[2]), .valid_weight_in(vw_s[2]), .weight_in(wi_s[2]),
      .valid_in(vi_s[2]), .pxl_in(pi_s[2]), .in_ready(ir_s[2]), .pxl_out(po_s[2]),
      .valid_out(vo_s[2]), .out_ready(or_s[2]), .frame_done(fd_s[2]));

   typedef struct {
      string            name;
      int               d;
      logic [3:0][15:0] w;
      logic [1:0][15:0] px;
      logic [1:0][15:0] exp;
   } vec_t;

   vec_t        vecs [5];
   logic [15:0] wbuf [16];
   logic [15:0] oq   [$];
   int          fd_cnt [3];
   int          act = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   // Record every consumed word of the active instance and every frame_done pulse.
   always @(negedge clk) begin
      if (vo_s[act] && or_s[act]) oq.push_back(po_s[act]);
      for (int d = 0; d < 3; d++)
         if (fd_s[d]) fd_cnt[d]++;
   end

   function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef CONV1X1_RELU_EN
      return x[15] ? 16'h0000 : x;
`else
      return x;
`endif
   endfunction

   function automatic vec_t mk(input string n, input int d,
                               input logic [15:0] w0, w1, w2, w3, p0, p1, e0, e1);
      vec_t v;
      v.name = n; v.d = d;
      v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
      v.px[0] = p0; v.px[1] = p1;
      v.exp[0] = relu(e0); v.exp[1] = relu(e1);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int d);
      vw_s[d] = 1'b0; vi_s[d] = 1'b0; or_s[d] = 1'b0;
      reset_s[d] = 1'b1;
      tick();
      reset_s[d] = 1'b0;
   endtask

   task automatic load_weights(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         vw_s[d] = 1'b1;
         wi_s[d] = wbuf[i];
         tick();
      end
      vw_s[d] = 1'b0;
   endtask

   task automatic load_pixel(input int d, input logic [15:0] p0, input logic [15:0] p1);
      logic [15:0] p [2];
      int t;
      p[0] = p0; p[1] = p1;
      for (int i = 0; i < 2; i++) begin
         vi_s[d] = 1'b1;
         pi_s[d] = p[i];
         t = 0;
         while (!ir_s[d] && t < 500) begin
            tick();
            t++;
         end
         if (!ir_s[d]) check("in_ready_timeout", 32'(ir_s[d]), 32'd1);
         tick();
      end
      vi_s[d] = 1'b0;
   endtask

   task automatic wait_out(input int n, input int budget, input string name);
      int t = 0;
      while (oq.size() < n && t < budget) begin
         tick();
         t++;
      end
      check(name, oq.size(), n);
   endtask

   int base, fd0, lat;
   logic seen_ready;

   initial begin
      for (int d = 0; d < 3; d++) begin
         reset_s[d] = 1'b1; vw_s[d] = 1'b0; wi_s[d] = '0;
         vi_s[d] = 1'b0; pi_s[d] = '0; or_s[d] = 1'b0;
      end
      vecs[0] = mk("basic",  0, 16'd1,    16'd2,    16'd3,    16'd4,    16'd5,    16'd6,    16'd17,   16'd39);
      vecs[1] = mk("sat_pos",0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      vecs[2] = mk("sat_neg",0, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF);
      vecs[3] = mk("sign",   0, 16'd1,    16'hFFFE, 16'd1,    16'd1,    16'd1,    16'd2,    16'hFFFD, 16'h0003);
      vecs[4] = mk("frac",   2, 16'h0180, 16'hFF00, 16'hFFFF, 16'h0000, 16'h0201, 16'h0080, 16'h0281, 16'hFFFD);
      repeat (2) tick();
      for (int d = 0; d < 3; d++) reset_s[d] = 1'b0;

      // Table: each vector from a fresh reset.
      for (int i = 0; i < 5; i++) begin
         act = vecs[i].d;
         do_reset(act);
         for (int k = 0; k < 4; k++) wbuf[k] = vecs[i].w[k];
         load_weights(act, 4);
         or_s[act] = 1'b1;
         base = oq.size();
         load_pixel(act, vecs[i].px[0], vecs[i].px[1]);
         wait_out(base + 2, 100, {vecs[i].name, "_count"});
         if (oq.size() >= base + 2) begin
            check({vecs[i].name, "_oc0"}, oq[base],     vecs[i].exp[0]);
            check({vecs[i].name, "_oc1"}, oq[base + 1], vecs[i].exp[1]);
         end
      end

      // Reset state, latency, frame with weight reload.
      act = 0;
      do_reset(0);
      check("rst_in_ready",   32'(ir_s[0]), 0);
      check("rst_valid_out",  32'(vo_s[0]), 0);
      check("rst_pxl_out",    32'(po_s[0]), 0);
      check("rst_frame_done", 32'(fd_s[0]), 0);
      wbuf[0] = 16'd1; wbuf[1] = 16'd2; wbuf[2] = 16'd3; wbuf[3] = 16'd4;
      load_weights(0, 4);
      or_s[0] = 1'b1;
      fd0  = fd_cnt[0];
      base = oq.size();
      load_pixel(0, 16'd5, 16'd6);
      lat = 0;
      while (lat < 50) begin
         lat++;
         @(negedge clk);
         if (vo_s[0]) break;
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      check("latency", lat, 5);
      wait_out(base + 2, 100, "frame_p0_count");
      if (oq.size() >= base + 2) begin
         check("frame_p0_oc0", oq[base],     16'd17);
         check("frame_p0_oc1", oq[base + 1], 16'd39);
      end
      check("frame_no_early_done", fd_cnt[0] - fd0, 0);
      base = oq.size();
      load_pixel(0, 16'd1, 16'd1);
      wait_out(base + 2, 100, "frame_p1_count");
      if (oq.size() >= base + 2) begin
         check("frame_p1_oc0", oq[base],     16'd3);
         check("frame_p1_oc1", oq[base + 1], 16'd7);
      end
      repeat (3) tick();
      check("frame_done_once", fd_cnt[0] - fd0, 1);
      repeat (20) tick();
      check("reload_in_ready_low", 32'(ir_s[0]), 0);
      wbuf[0] = 16'd1; wbuf[1] = 16'd0; wbuf[2] = 16'd0; wbuf[3] = 16'd1;
      load_weights(0, 4);
      check("reload_in_ready_high", 32'(ir_s[0]), 1);
      base = oq.size();
      load_pixel(0, 16'd9, 16'd4);
      wait_out(base + 2, 100, "reload_count");
      if (oq.size() >= base + 2) begin
         check("reload_oc0", oq[base],     16'd9);
         check("reload_oc1", oq[base + 1], 16'd4);
      end

      // Backpressure with COUT=8 into a 4-deep FIFO, then second pixel closes the frame.
      act = 1;
      do_reset(1);
      for (int oc = 0; oc < 8; oc++) begin
         wbuf[2 * oc]     = 16'(oc + 1);
         wbuf[2 * oc + 1] = 16'd1;
      end
      load_weights(1, 16);
      or_s[1] = 1'b0;
      fd0  = fd_cnt[1];
      base = oq.size();
      load_pixel(1, 16'd10, 16'd1);
      repeat (60) tick();
      check("bp_valid",      32'(vo_s[1]), 1);
      check("bp_head",       32'(po_s[1]), 11);
      check("bp_mac_stalled", 32'(ir_s[1]), 0);
      or_s[1] = 1'b1;
      wait_out(base + 8, 200, "bp_count");
      for (int oc = 0; oc < 8; oc++)
         if (oq.size() > base + oc)
            check($sformatf("bp_oc%0d", oc), oq[base + oc], 10 * (oc + 1) + 1);
      repeat (20) tick();
      check("bp_no_dup", oq.size() - base, 8);
      check("bp_no_done", fd_cnt[1] - fd0, 0);
      base = oq.size();
      load_pixel(1, 16'd1, 16'd2);
      wait_out(base + 8, 200, "keep_count");
      for (int oc = 0; oc < 8; oc++)
         if (oq.size() > base + oc)
            check($sformatf("keep_oc%0d", oc), oq[base + oc], oc + 3);
      repeat (5) tick();
      check("keep_done_once", fd_cnt[1] - fd0, 1);
      check("keep_in_ready", 32'(ir_s[1]), 1);

      // Reset in the middle of COMPUTE.
      do_reset(1);
      load_weights(1, 16);
      or_s[1] = 1'b1;
      load_pixel(1, 16'd10, 16'd1);
      repeat (3) tick();
      reset_s[1] = 1'b1;
      tick();
      reset_s[1] = 1'b0;
      check("midrst_valid_out",  32'(vo_s[1]), 0);
      check("midrst_in_ready",   32'(ir_s[1]), 0);
      check("midrst_frame_done", 32'(fd_s[1]), 0);
      base = oq.size();
      seen_ready = 1'b0;
      vi_s[1] = 1'b1;
      pi_s[1] = 16'd7;
      repeat (30) begin
         if (ir_s[1]) seen_ready = 1'b1;
         tick();
      end
      vi_s[1] = 1'b0;
      check("midrst_no_ready", 32'(seen_ready), 0);
      check("midrst_no_output", oq.size() - base, 0);
      load_weights(1, 16);
      check("midrst_reloaded", 32'(ir_s[1]), 1);
      base = oq.size();
      load_pixel(1, 16'd10, 16'd1);
      wait_out(base + 1, 100, "midrst_first_count");
      if (oq.size() > base) check("midrst_first", oq[base], 16'd11);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
